// File: rtl/alto_task_scheduler.sv
// alto_task_scheduler: fixed-priority microcode task arbiter with per-task saved MPC file
module alto_task_scheduler #(
    parameter int TASKS     = 16,
    parameter int MPC_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [TASKS-1:0]     wakeup_i,
    input  logic                 task_i,
    input  logic                 block_i,
    input  logic                 stall_i,
    input  logic [MPC_WIDTH-1:0] next_mpc_i,
    output logic [3:0]           current_task_o,
    output logic [MPC_WIDTH-1:0] mpc_o,
    output logic                 mpc_load_o,
    output logic [TASKS-1:0]     pending_o
);
    localparam int TW = $clog2(TASKS);

    logic [TASKS-1:0]     wake_q, wake_d, blocked_q, blocked_d, cur_oh, eligible;
    logic [TW-1:0]        cur_q, cur_d, winner;
    logic [MPC_WIDTH-1:0] saved_q [TASKS];
    logic [MPC_WIDTH-1:0] saved_d [TASKS];
    logic                 blk_now, sw;

    // BLOCK masks the running task in this same arbitration; bit 0 is always eligible
    always_comb begin
        blk_now  = block_i & ~stall_i & (cur_q != '0);
        cur_oh   = blk_now ? (TASKS'(1) << cur_q) : '0;
        eligible = (wake_q & ~blocked_q & ~cur_oh) | TASKS'(1);
    end

    // highest set eligible bit wins
    always_comb begin
        winner = '0;
        for (int i = 0; i < TASKS; i++)
            if (eligible[i]) winner = TW'(i);
    end

    // restart address bypasses the file when the task does not change
    always_comb begin
        sw             = task_i & ~stall_i & ~rst_i;
        mpc_load_o     = sw;
        mpc_o          = (winner == cur_q) ? next_mpc_i : saved_q[winner];
        pending_o      = eligible;
        current_task_o = 4'(cur_q);
    end

    // next state: block set beats clear-on-dropped-wakeup, stall freezes everything but wake
    always_comb begin
        wake_d    = wakeup_i;
        blocked_d = stall_i ? blocked_q : ((blocked_q & wake_q) | cur_oh);
        cur_d     = sw ? winner : cur_q;
        saved_d   = saved_q;
        if (sw) saved_d[cur_q] = next_mpc_i;
    end

    // state registers; saved MPCs reset to their own task number
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wake_q    <= '0;
            blocked_q <= '0;
            cur_q     <= '0;
            for (int i = 0; i < TASKS; i++) saved_q[i] <= MPC_WIDTH'(i);
        end else begin
            wake_q    <= wake_d;
            blocked_q <= blocked_d;
            cur_q     <= cur_d;
            saved_q   <= saved_d;
        end
    end
endmodule

// File: tb/tb_alto_task_scheduler.sv
// tb_alto_task_scheduler: randomized and directed check against a task-level scheduler model
module tb_alto_task_scheduler;
    logic        clk_i = 0, rst_i = 1;
    logic [15:0] wakeup_i = 0;
    logic        task_i = 0, block_i = 0, stall_i = 0;
    logic [11:0] next_mpc_i = 0;
    logic [3:0]  current_task_o;
    logic [11:0] mpc_o;
    logic        mpc_load_o;
    logic [15:0] pending_o;

    int total = 0, bad = 0;

    bit [15:0] m_wake, m_blk;
    int        m_cur;
    bit [11:0] m_saved [16];

    alto_task_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .wakeup_i(wakeup_i), .task_i(task_i),
        .block_i(block_i), .stall_i(stall_i), .next_mpc_i(next_mpc_i),
        .current_task_o(current_task_o), .mpc_o(mpc_o), .mpc_load_o(mpc_load_o),
        .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wake = 0;
        m_blk  = 0;
        m_cur  = 0;
        for (int k = 0; k < 16; k++) m_saved[k] = 12'(k);
    endtask

    // compare combinational outputs at the negedge and advance the model to the next edge
    task automatic drv(input bit [15:0] w, input bit t, input bit b, input bit s, input bit [11:0] n, input bit rst_mid = 0);
        bit [15:0] elig;
        int        win;
        bit        blk_now, sw;
        wakeup_i = w; task_i = t; block_i = b; stall_i = s; next_mpc_i = n;
        if (rst_mid) begin
            #2 rst_i = 1;
            #1;
            check("rst_cur", 32'(current_task_o), 0);
            check("rst_load", 32'(mpc_load_o), 0);
            check("rst_pend", 32'(pending_o), 32'h1);
            model_reset();
            @(negedge clk_i);
            @(posedge clk_i);
            #1 rst_i = 0;
            return;
        end
        @(negedge clk_i);
        blk_now = b && !s && m_cur != 0;
        elig = m_wake & ~m_blk;
        if (blk_now) elig[m_cur] = 0;
        elig[0] = 1;
        win = 0;
        for (int k = 15; k >= 0; k--)
            if (elig[k]) begin win = k; break; end
        sw = t && !s;
        check("cur", 32'(current_task_o), 32'(m_cur));
        check("pending", 32'(pending_o), 32'(elig));
        check("load", 32'(mpc_load_o), 32'(sw));
        if (sw) check("mpc", 32'(mpc_o), 32'(win == m_cur ? n : m_saved[win]));
        if (!s) begin
            for (int k = 0; k < 16; k++) if (!m_wake[k]) m_blk[k] = 0;
            if (blk_now) m_blk[m_cur] = 1;
        end
        if (sw) begin
            m_saved[m_cur] = n;
            m_cur = win;
        end
        m_wake = w;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit [15:0] w;
        model_reset();
        task_i = 1;
        next_mpc_i = 12'h3c5;
        #22;
        check("rst_hold_cur", 32'(current_task_o), 0);
        check("rst_hold_load", 32'(mpc_load_o), 0);
        check("rst_hold_pend", 32'(pending_o), 32'h1);
        check("rst_hold_mpc", 32'(mpc_o), 32'h3c5);
        rst_i = 0;
        task_i = 0;
        @(posedge clk_i);
        #1;
        drv(16'h0000, 0, 0, 0, 12'h000);
        drv(16'h0000, 1, 0, 0, 12'h123);
        check("bypass_cur0", 32'(current_task_o), 0);
        drv(16'h0890, 0, 0, 0, 12'h000);
        drv(16'h0890, 1, 0, 0, 12'h055);
        check("to_task11", 32'(current_task_o), 11);
        drv(16'h0890, 1, 1, 0, 12'h200);
        check("block_to7", 32'(current_task_o), 7);
        drv(16'h0890, 1, 0, 0, 12'h201);
        drv(16'h0890, 1, 0, 0, 12'h202);
        check("11_stays_blocked", 32'(current_task_o), 7);
        drv(16'h0090, 0, 0, 0, 12'h000);
        drv(16'h0890, 0, 0, 0, 12'h000);
        drv(16'h0890, 0, 0, 0, 12'h000);
        check("11_rearmed", 32'(pending_o[11]), 1);
        for (int i = 0; i < 3; i++) drv(16'h0890, 1, 1, 1, 12'h3aa);
        check("stall_hold", 32'(current_task_o), 7);
        drv(16'h0890, 1, 0, 0, 12'h301);
        check("one_switch", 32'(current_task_o), 11);
        drv(16'h0000, 0, 0, 0, 12'h000);
        drv(16'h0000, 1, 0, 0, 12'h310);
        check("back_to0", 32'(current_task_o), 0);
        drv(16'h0000, 0, 1, 0, 12'h000);
        check("blk_task0_pend", 32'(pending_o), 32'h1);
        drv(16'h0080, 0, 0, 0, 12'h000);
        drv(16'h0080, 1, 0, 0, 12'h320);
        drv(16'h0880, 1, 0, 0, 12'h330, 1);
        drv(16'h0080, 0, 0, 0, 12'h000);
        drv(16'h0080, 1, 0, 0, 12'h340);
        check("saved7_reset", 32'(current_task_o), 7);
        w = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) w ^= 16'(1 << $urandom_range(15));
            drv(w, $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                12'($urandom), $urandom_range(199) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alto_task_scheduler.md
# alto_task_scheduler

Microcode task scheduler for the Alto microengine. Registers the sixteen device wakeup lines and arbitrates them by fixed priority when a microinstruction executes the TASK function. Keeps a saved microprogram counter per task and supplies the restart address of the winning task to the microsequencer. Owns the `current_task` value consumed by every task-qualified block, including emulator support.

## Interface
Parameters:
- `TASKS`, 16: number of tasks. Fixed; task 0 is the emulator, and a higher number means higher priority.
- `MPC_WIDTH`, 12: microprogram counter width.

Ports:
- `clk_i`  in  1  microcycle clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `wakeup_i`  in  16  level wakeup requests, one per task; bit 0 is ignored.
- `task_i`  in  1  decoded F1 TASK function of the executing microinstruction.
- `block_i`  in  1  decoded F1 BLOCK function of the executing microinstruction.
- `stall_i`  in  1  microengine stall; the current microinstruction does not retire.
- `next_mpc_i`  in  12  successor address of the executing microinstruction.
- `current_task_o`  out  4  task owning the executing microinstruction.
- `mpc_o`  out  12  restart address. Valid while `mpc_load_o` is high.
- `mpc_load_o`  out  1  when high, the microsequencer loads `mpc_o` instead of `next_mpc_i` at this edge.
- `pending_o`  out  16  eligible-task mask, for status and debug.

## Operation
State:
- `wake_q[15:0]`: wakeup register.
- `blocked[15:0]`: block flags.
- `cur[3:0]`: current task.
- `saved[0..15]`: 12-bit saved MPC per task.

Wakeup register:
- Each edge, `wake_q <= wakeup_i`, independent of stall.

Block handshake:
- `blk_now = block_i & !stall_i & (cur != 0)`.
- When `blk_now` is high, `blocked[cur]` sets.
- `blocked[k]` clears on the edge where `wake_q[k] == 0`. The device must drop its wakeup before it can be re-armed.
- Set has priority over clear in the same cycle.

Eligibility:
- `eligible = (wake_q & ~blocked & ~(blk_now ? onehot(cur) : 0)) | 16'h0001`.
- `pending_o = eligible`. This is combinational, so a BLOCK takes effect in the same arbitration.

Arbitration:
- `winner` is the highest set bit of `eligible`. It is always defined, because bit 0 is always set.

Task switch (`sw = task_i & !stall_i & !rst_i`):
- `mpc_load_o = sw`.
- `mpc_o = (winner == cur) ? next_mpc_i : saved[winner]`. This is combinational and bypasses the file when the task does not change.
- On the edge: `saved[cur] <= next_mpc_i`, then `cur <= winner`.
- A switch to the same task is legal: `saved[cur]` is rewritten and `cur` is unchanged.

Non-TASK cycles:
- `cur` and `saved` hold.
- `mpc_load_o = 0`.

Stall:
- `blocked`, `cur` and `saved` hold.
- `task_i` and `block_i` are ignored.

Reset:
- `cur = 0`, `blocked = 0`, `wake_q = 0`, `saved[k] = k` (zero-extended task number).
- Outputs: `current_task_o = 0`, `mpc_load_o = 0`, `pending_o = 16'h0001`.
- `mpc_o = next_mpc_i` when `cur` is 0, since `winner == cur` selects the bypass.
- Reset asserted mid-operation discards any pending switch on that edge.

## Timing
- A wakeup visible on `wakeup_i` at edge N appears in `eligible` during cycle N+1. This is one cycle of wakeup latency.
- TASK executes in cycle C. `mpc_o` and `mpc_load_o` are valid combinationally in C. `current_task_o` changes after the edge ending C.
- The first microinstruction of the new task executes in C+1.
- BLOCK in cycle C masks `cur` for arbitration in C. `blocked` is visible from C+1.
- `blocked[k]` clear: `wake_q[k] == 0` in cycle D clears it at the end of D. A wakeup reasserted in D+1 is registered at the end of D+1 and is eligible in D+2.
- No multi-cycle paths. `mpc_o` is a 16:1 mux from the priority encoder plus a bypass compare, all in one cycle.

## Test plan
- Reset, then release with `wakeup_i=0`:
  - `current_task_o=0`, `pending_o=0x0001`.
  - TASK with `next_mpc_i=0x123` gives `mpc_load_o=1` and `mpc_o=0x123` (bypass); `cur` stays 0.
- `wakeup_i=0x0890`, wait 1 cycle, then TASK with `next_mpc_i=0x055`:
  - `mpc_o=0x00B` (reset value of `saved[11]`).
  - Next cycle `current_task_o=11`, and `saved[0]` reads back `0x055` on a later switch to 0.
- Running task 11, BLOCK+TASK in the same cycle with `wakeup_i` unchanged:
  - Winner is 7.
  - After `wakeup_i[11]` stays high, 11 is not eligible again.
  - Drop `wakeup_i[11]` one cycle, then reraise: 11 is eligible two cycles after reraise.
- `stall_i=1` with `task_i=1` and `block_i=1` for 3 cycles:
  - `mpc_load_o=0`; `cur`, `blocked` and `saved` are unchanged.
  - Releasing the stall performs exactly one switch.
- BLOCK while in task 0:
  - No `blocked` bit changes.
  - `pending_o` bit 0 remains 1.
- Assert `rst_i` asynchronously mid-cycle while in task 7 with pending switches:
  - `current_task_o` goes to 0 immediately, `mpc_load_o` goes to 0.
  - After release, `saved[7]=0x007`.
